// File: rtl/sc_micro_sequencer.sv
// Microprogram sequencer: microPC, MIR, PSR, next-address selection and a
// return-address stack for CALL/RET microsubroutines. Control store is external.
module sc_micro_sequencer #(
  parameter int ADDRWIDTH  = 11,
  parameter int OPWIDTH    = 8,
  parameter int CONDWIDTH  = 4,
  parameter int DPWIDTH    = 30,
  parameter int STACKDEPTH = 4,
  parameter int MIRWIDTH   = DPWIDTH + CONDWIDTH + ADDRWIDTH
) (
  input  logic                 SC_MicroSeq_CLOCK_50,
  input  logic                 SC_MicroSeq_RESET_InHigh,
  input  logic                 SC_MicroSeq_Stall_InHigh,
  input  logic [3:0]           SC_MicroSeq_Flags_In,
  input  logic                 SC_MicroSeq_FlagsWrite_InLow,
  input  logic                 SC_MicroSeq_IR13_In,
  input  logic [OPWIDTH-1:0]   SC_MicroSeq_IR_OP_In,
  input  logic [MIRWIDTH-1:0]  SC_MicroSeq_Store_InBUS,
  output logic [ADDRWIDTH-1:0] SC_MicroSeq_Addr_OutBUS,
  output logic [DPWIDTH-1:0]   SC_MicroSeq_DP_OutBUS,
  output logic [3:0]           SC_MicroSeq_Psr_Out,
  output logic                 SC_MicroSeq_Taken_Out,
  output logic                 SC_MicroSeq_StackErr_Out
);

  localparam int SPWIDTH    = $clog2(STACKDEPTH + 1);
  localparam int IDXWIDTH   = (STACKDEPTH > 1) ? $clog2(STACKDEPTH) : 1;
  localparam int STACKSLOTS = 1 << IDXWIDTH;

  localparam logic [CONDWIDTH-1:0] COND_JN     = CONDWIDTH'(1);
  localparam logic [CONDWIDTH-1:0] COND_JZ     = CONDWIDTH'(2);
  localparam logic [CONDWIDTH-1:0] COND_JV     = CONDWIDTH'(3);
  localparam logic [CONDWIDTH-1:0] COND_JC     = CONDWIDTH'(4);
  localparam logic [CONDWIDTH-1:0] COND_JIR13  = CONDWIDTH'(5);
  localparam logic [CONDWIDTH-1:0] COND_JMP    = CONDWIDTH'(6);
  localparam logic [CONDWIDTH-1:0] COND_DECODE = CONDWIDTH'(7);
  localparam logic [CONDWIDTH-1:0] COND_CALL   = CONDWIDTH'(8);
  localparam logic [CONDWIDTH-1:0] COND_RET    = CONDWIDTH'(9);
  localparam logic [CONDWIDTH-1:0] COND_JNZ    = CONDWIDTH'(10);
  localparam logic [CONDWIDTH-1:0] COND_JNC    = CONDWIDTH'(11);

  logic                 clk;
  logic                 srst;
  logic [MIRWIDTH-1:0]  mirReg;
  logic [ADDRWIDTH-1:0] upcReg;
  logic [3:0]           psrReg;
  logic [SPWIDTH-1:0]   spReg;
  logic                 stackErrReg;
  logic [ADDRWIDTH-1:0] stackMem [STACKSLOTS];

  logic [CONDWIDTH-1:0] condField;
  logic [ADDRWIDTH-1:0] jumpAddr;
  logic [ADDRWIDTH-1:0] seqAddr;
  logic [ADDRWIDTH-1:0] topAddr;
  logic [ADDRWIDTH-1:0] decodeAddr;
  logic [ADDRWIDTH-1:0] nextAddr;
  logic                 takenNext;
  logic                 isCall;
  logic                 isRet;
  logic                 stackEmpty;
  logic                 stackFull;
  logic                 advance;

  assign clk        = SC_MicroSeq_CLOCK_50;
  assign srst       = SC_MicroSeq_RESET_InHigh;
  assign advance    = ~SC_MicroSeq_Stall_InHigh;
  assign condField  = mirReg[ADDRWIDTH +: CONDWIDTH];
  assign jumpAddr   = mirReg[ADDRWIDTH-1:0];
  assign seqAddr    = upcReg + ADDRWIDTH'(1);
  assign stackEmpty = (spReg == '0);
  assign stackFull  = (spReg == SPWIDTH'(STACKDEPTH));
  assign topAddr    = stackMem[IDXWIDTH'(spReg - SPWIDTH'(1))];
  // DECODE lands on a 4-word-aligned slot in the upper half of microstore
  assign decodeAddr = {1'b1, SC_MicroSeq_IR_OP_In, {(ADDRWIDTH-OPWIDTH-1){1'b0}}};

  always_comb begin
    nextAddr  = seqAddr;
    takenNext = 1'b0;
    isCall    = 1'b0;
    isRet     = 1'b0;
    case (condField)
      COND_JN:     takenNext = psrReg[3];
      COND_JZ:     takenNext = psrReg[2];
      COND_JV:     takenNext = psrReg[1];
      COND_JC:     takenNext = psrReg[0];
      COND_JIR13:  takenNext = SC_MicroSeq_IR13_In;
      COND_JNZ:    takenNext = ~psrReg[2];
      COND_JNC:    takenNext = ~psrReg[0];
      COND_JMP:    takenNext = 1'b1;
      COND_DECODE: takenNext = 1'b1;
      COND_CALL: begin
        takenNext = 1'b1;
        isCall    = 1'b1;
      end
      COND_RET: begin
        takenNext = 1'b1;
        isRet     = 1'b1;
      end
      default: ;
    endcase
    if (takenNext) begin
      if (condField == COND_DECODE)
        nextAddr = decodeAddr;
      else if (isRet)
        nextAddr = stackEmpty ? '0 : topAddr;
      else
        nextAddr = jumpAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      mirReg      <= '0;
      upcReg      <= '1;
      psrReg      <= '0;
      spReg       <= '0;
      stackErrReg <= 1'b0;
    end else if (advance) begin
      mirReg <= SC_MicroSeq_Store_InBUS;
      upcReg <= nextAddr;
      if (!SC_MicroSeq_FlagsWrite_InLow)
        psrReg <= SC_MicroSeq_Flags_In;
      // A full-stack CALL still jumps; only the return address is lost
      if (isCall) begin
        if (stackFull) stackErrReg <= 1'b1;
        else           spReg <= spReg + SPWIDTH'(1);
      end else if (isRet) begin
        if (stackEmpty) stackErrReg <= 1'b1;
        else            spReg <= spReg - SPWIDTH'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < STACKSLOTS; gi++) begin : gStackSlot
      always_ff @(posedge clk) begin
        if (!srst && advance && isCall && !stackFull && (IDXWIDTH'(spReg) == IDXWIDTH'(gi)))
          stackMem[gi] <= seqAddr;
      end
    end
  endgenerate

  assign SC_MicroSeq_Addr_OutBUS  = nextAddr;
  assign SC_MicroSeq_DP_OutBUS    = mirReg[MIRWIDTH-1 -: DPWIDTH];
  assign SC_MicroSeq_Psr_Out      = psrReg;
  assign SC_MicroSeq_Taken_Out    = takenNext;
  assign SC_MicroSeq_StackErr_Out = stackErrReg;

endmodule
